// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: validates a byte PC against the instruction window,
// runs a req/ack word read with a bounded wait, and reports data or a fault code.
module imem_fetch_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          ADDR_W    = 10,
  parameter int          TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc_in,
  input  logic              fetch_req,
  output logic              fetch_busy,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [1:0]  CODE_NONE     = 2'b00;
  localparam logic [1:0]  CODE_MISALIGN = 2'b01;
  localparam logic [1:0]  CODE_RANGE    = 2'b10;
  localparam logic [1:0]  CODE_TIMEOUT  = 2'b11;

  // Window bounds carried in 33 bits so BASE + size never wraps past 2**32.
  localparam logic [32:0] WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI   = WIN_LO + (33'd4 << ADDR_W);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_count;
  logic [1:0] accept_code;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  function automatic logic out_of_window(input logic [31:0] addr);
    logic [32:0] wide;
    wide = {1'b0, addr};
    return (wide < WIN_LO) || (wide >= WIN_HI);
  endfunction

  function automatic logic [ADDR_W-1:0] word_index(input logic [31:0] addr);
    return ADDR_W'((addr - BASE_ADDR) >> 2);
  endfunction

  // Classify the presented PC; misalignment outranks the range check.
  always_comb begin
    accept_code = CODE_NONE;
    if (is_misaligned(pc_in)) begin
      accept_code = CODE_MISALIGN;
    end else if (out_of_window(pc_in)) begin
      accept_code = CODE_RANGE;
    end else begin
      accept_code = CODE_NONE;
    end
  end

  // Fetch FSM with all outputs registered; valid/fault are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr_out   <= 32'h0000_0000;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= CODE_NONE;
      wait_count  <= 8'd0;
    end else begin
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req) begin
            if (accept_code != CODE_NONE) begin
              fault      <= 1'b1;
              fault_code <= accept_code;
            end else begin
              mem_addr   <= word_index(pc_in);
              mem_req    <= 1'b1;
              wait_count <= 8'd0;
              fault_code <= CODE_NONE;
              state      <= WAIT;
            end
          end
        end
        WAIT: begin
          // An ack on the final allowed cycle still completes the fetch.
          if (mem_ack) begin
            instr_out   <= mem_rdata;
            instr_valid <= 1'b1;
            mem_req     <= 1'b0;
            state       <= IDLE;
          end else if (wait_count == TMO_LAST) begin
            fault      <= 1'b1;
            fault_code <= CODE_TIMEOUT;
            mem_req    <= 1'b0;
            state      <= IDLE;
          end else begin
            wait_count <= wait_count + 8'd1;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign fetch_busy = (state == WAIT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized self-checking bench for imem_fetch_ctrl against a transaction-level model
// of the fetch rules (window classification, word index, ack-or-timeout outcome).
module tb_imem_fetch_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam longint      WORDS = 1024;
  localparam int          TMO   = 16;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        fetch_req;
  logic        fetch_busy;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        fault;
  logic [1:0]  fault_code;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_instr;
  logic [1:0]  exp_code;

  imem_fetch_ctrl #(.BASE_ADDR(BASE), .ADDR_W(10), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .fetch_req(fetch_req),
    .fetch_busy(fetch_busy), .instr_out(instr_out), .instr_valid(instr_valid),
    .fault(fault), .fault_code(fault_code), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] classify(input logic [31:0] pc);
    longint p;
    p = longint'(pc);
    if (pc % 4 != 0) return 2'b01;
    if (p < longint'(BASE) || p >= longint'(BASE) + 4 * WORDS) return 2'b10;
    return 2'b00;
  endfunction

  // One fetch transaction; delay = cycle (1-based) in which ack is driven, >TMO means never.
  task automatic do_fetch(input logic [31:0] pc, input int delay, input logic [31:0] rdata,
                          input bit noisy, input bit b2b, input string tag);
    logic [1:0] cls;
    logic [9:0] eaddr;
    int c;
    bit done;
    cls   = classify(pc);
    eaddr = 10'((pc - BASE) / 4);
    fetch_req = 1'b1;
    pc_in     = pc;
    mem_ack   = 1'b0;
    @(negedge clk);
    fetch_req = 1'b0;
    if (cls != 2'b00) begin
      nvec++;
      if (fault !== 1'b1 || fault_code !== cls || mem_req !== 1'b0 || fetch_busy !== 1'b0 || instr_valid !== 1'b0) begin
        nerr++;
        $display("FAIL %s reject pc=%h: fault=%b code=%b req=%b busy=%b valid=%b, want fault=1 code=%b req=0 busy=0 valid=0",
                 tag, pc, fault, fault_code, mem_req, fetch_busy, instr_valid, cls);
      end
      exp_code = cls;
    end else begin
      c = 1;
      done = 1'b0;
      while (!done) begin
        nvec++;
        if (mem_req !== 1'b1 || fetch_busy !== 1'b1 || mem_addr !== eaddr || fault !== 1'b0 ||
            instr_valid !== 1'b0 || fault_code !== 2'b00) begin
          nerr++;
          $display("FAIL %s wait cycle %0d pc=%h: req=%b busy=%b addr=%h fault=%b valid=%b code=%b, want 1 1 %h 0 0 00",
                   tag, c, pc, mem_req, fetch_busy, mem_addr, fault, instr_valid, fault_code, eaddr);
        end
        if (noisy) begin
          fetch_req = 1'b1;
          pc_in     = $urandom;
        end
        if (c == delay) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end else begin
          mem_rdata = $urandom;
        end
        if (c == delay || c == TMO) done = 1'b1;
        else c++;
        @(negedge clk);
        mem_ack   = 1'b0;
        fetch_req = 1'b0;
      end
      nvec++;
      if (delay <= TMO) begin
        if (instr_valid !== 1'b1 || instr_out !== rdata || fault !== 1'b0 || fault_code !== 2'b00 ||
            mem_req !== 1'b0 || fetch_busy !== 1'b0) begin
          nerr++;
          $display("FAIL %s complete: valid=%b instr=%h fault=%b code=%b req=%b busy=%b, want 1 %h 0 00 0 0",
                   tag, instr_valid, instr_out, fault, fault_code, mem_req, fetch_busy, rdata);
        end
        exp_instr = rdata;
        exp_code  = 2'b00;
      end else begin
        if (fault !== 1'b1 || fault_code !== 2'b11 || instr_valid !== 1'b0 || mem_req !== 1'b0 ||
            fetch_busy !== 1'b0 || instr_out !== exp_instr) begin
          nerr++;
          $display("FAIL %s timeout: fault=%b code=%b valid=%b req=%b busy=%b instr=%h, want 1 11 0 0 0 %h",
                   tag, fault, fault_code, instr_valid, mem_req, fetch_busy, instr_out, exp_instr);
        end
        exp_code = 2'b11;
      end
    end
    if (!b2b) begin
      if ($urandom_range(0, 1) == 1) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      nvec++;
      if (instr_valid !== 1'b0 || fault !== 1'b0 || mem_req !== 1'b0 || fetch_busy !== 1'b0 ||
          fault_code !== exp_code || instr_out !== exp_instr) begin
        nerr++;
        $display("FAIL %s idle tail: valid=%b fault=%b req=%b busy=%b code=%b instr=%h, want 0 0 0 0 %b %h",
                 tag, instr_valid, fault, mem_req, fetch_busy, fault_code, instr_out, exp_code, exp_instr);
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    fetch_req = 1'b1;
    mem_ack   = 1'b1;
    pc_in     = BASE;
    mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nvec++;
      if (mem_req !== 1'b0 || mem_addr !== 10'd0 || instr_out !== 32'd0 || instr_valid !== 1'b0 ||
          fault !== 1'b0 || fault_code !== 2'b00 || fetch_busy !== 1'b0) begin
        nerr++;
        $display("FAIL reset cycle %0d: req=%b addr=%h instr=%h valid=%b fault=%b code=%b busy=%b, want all zero",
                 i, mem_req, mem_addr, instr_out, instr_valid, fault, fault_code, fetch_busy);
      end
    end
    reset     = 1'b0;
    fetch_req = 1'b0;
    mem_ack   = 1'b0;
    @(negedge clk);
    nvec++;
    if (mem_req !== 1'b0 || fetch_busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset release: req=%b busy=%b, want 0 0", mem_req, fetch_busy);
    end
    exp_instr = 32'd0;
    exp_code  = 2'b00;
  endtask

  task automatic test_min_latency();
    do_fetch(32'h0000_3000, 1, 32'h8C01_0000, 1'b0, 1'b0, "min_latency");
  endtask

  task automatic test_window_edges();
    do_fetch(32'h0000_3FFC, 3, 32'h1234_5678, 1'b0, 1'b0, "top_word");
    do_fetch(32'h0000_4000, 1, 32'h0, 1'b0, 1'b0, "above_window");
    do_fetch(32'h0000_2FFC, 1, 32'h0, 1'b0, 1'b0, "below_window");
    do_fetch(32'hFFFF_FFFC, 1, 32'h0, 1'b0, 1'b0, "no_wrap");
  endtask

  task automatic test_misaligned();
    do_fetch(32'h0000_3002, 1, 32'h0, 1'b0, 1'b0, "misaligned");
    do_fetch(32'h0000_1001, 1, 32'h0, 1'b0, 1'b0, "misaligned_priority");
    do_fetch(32'h0000_3010, 2, 32'hCAFE_0001, 1'b0, 1'b0, "clear_code");
  endtask

  task automatic test_timeout();
    do_fetch(32'h0000_3100, TMO + 5, 32'h0, 1'b0, 1'b0, "timeout");
    do_fetch(32'h0000_3104, TMO, 32'hA5A5_0F0F, 1'b0, 1'b0, "ack_on_last");
  endtask

  task automatic test_hold_in_wait();
    do_fetch(32'h0000_3200, 5, 32'h0BAD_F00D, 1'b1, 1'b0, "req_held_in_wait");
  endtask

  task automatic test_reset_mid_wait();
    fetch_req = 1'b1;
    pc_in     = 32'h0000_3040;
    @(negedge clk);
    fetch_req = 1'b0;
    nvec++;
    if (mem_req !== 1'b1 || mem_addr !== 10'h010) begin
      nerr++;
      $display("FAIL mid_wait start: req=%b addr=%h, want 1 010", mem_req, mem_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nvec++;
    if (mem_req !== 1'b0 || fetch_busy !== 1'b0 || instr_out !== 32'd0 || fault_code !== 2'b00 ||
        mem_addr !== 10'd0 || instr_valid !== 1'b0 || fault !== 1'b0) begin
      nerr++;
      $display("FAIL mid_wait reset: req=%b busy=%b instr=%h code=%b addr=%h valid=%b fault=%b, want all zero",
               mem_req, fetch_busy, instr_out, fault_code, mem_addr, instr_valid, fault);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ack = 1'b0;
    nvec++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0 || fetch_busy !== 1'b0 || instr_out !== 32'd0) begin
      nerr++;
      $display("FAIL late_ack: valid=%b req=%b busy=%b instr=%h, want 0 0 0 00000000",
               instr_valid, mem_req, fetch_busy, instr_out);
    end
    exp_instr = 32'd0;
    exp_code  = 2'b00;
  endtask

  task automatic test_back_to_back();
    do_fetch(32'h0000_3300, 1, 32'h1111_2222, 1'b0, 1'b1, "b2b_after_valid");
    do_fetch(32'h0000_3302, 1, 32'h0, 1'b0, 1'b1, "b2b_reject");
    do_fetch(32'h0000_3304, 2, 32'h3333_4444, 1'b0, 1'b1, "b2b_after_fault");
    do_fetch(32'h0000_3308, TMO + 1, 32'h0, 1'b0, 1'b1, "b2b_timeout");
    do_fetch(32'h0000_330C, 1, 32'h5555_6666, 1'b0, 1'b0, "b2b_after_timeout");
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    pc = BASE + 4 * $urandom_range(0, 1023);
        2:       pc = BASE + 4 * $urandom_range(0, 1023) + $urandom_range(1, 3);
        3:       pc = 4 * $urandom_range(0, 32'h0000_0BFF);
        4:       pc = BASE + 32'd4096 + 4 * $urandom_range(0, 1000000);
        default: pc = 32'hFFFF_FFFC - 4 * $urandom_range(0, 15);
      endcase
      do_fetch(pc, $urandom_range(1, TMO + 4), $urandom, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, "random");
    end
  endtask

  initial begin
    reset     = 1'b1;
    fetch_req = 1'b0;
    mem_ack   = 1'b0;
    pc_in     = 32'd0;
    mem_rdata = 32'd0;
    exp_instr = 32'd0;
    exp_code  = 2'b00;
    test_reset();
    test_min_latency();
    test_window_edges();
    test_misaligned();
    test_timeout();
    test_hold_in_wait();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch controller between the program counter and a handshaked instruction memory. Accepts a fetch request for a byte address, validates it against the instruction-memory window, issues a word-indexed read with a req/ack handshake, and returns the instruction as a one-cycle valid pulse. Bad addresses and unresponsive memory produce a one-cycle fault pulse and a held fault code. Upstream PC logic stalls while `fetch_busy` is high.

## Interface
- BASE_ADDR, 32'h00003000, byte address of instruction word 0
- ADDR_W, 10, word-index width; window holds 2**ADDR_W words
- TIMEOUT, 16, max cycles `mem_req` stays high awaiting `mem_ack` (1..255)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- pc_in  in  32  byte address to fetch, sampled when a request is accepted
- fetch_req  in  1  fetch request, level-sampled each edge
- fetch_busy  out  1  high while a memory read is in flight (state WAIT)
- instr_out  out  32  last fetched instruction, held until next successful fetch
- instr_valid  out  1  one-cycle pulse: `instr_out` updated
- fault  out  1  one-cycle pulse: request rejected or timed out
- fault_code  out  2  00 none, 01 misaligned, 10 out of range, 11 timeout; held
- mem_req  out  1  memory read request, level, held until ack or timeout
- mem_addr  out  ADDR_W  word index = (pc_in - BASE_ADDR) >> 2, held while `mem_req`
- mem_ack  in  1  memory read complete, `mem_rdata` valid this cycle
- mem_rdata  in  32  read data

## Operation
- States: IDLE, WAIT. Reset → IDLE.
- Reset values: `mem_req`=0, `mem_addr`=0, `instr_out`=0, `instr_valid`=0, `fault`=0, `fault_code`=00, timeout counter=0, `fetch_busy`=0.
- IDLE, `fetch_req`=1 at an edge (request accepted), checks in priority order:
  - `pc_in[1:0]`≠0 → `fault`=1, `fault_code`=01, stay IDLE, no `mem_req`.
  - `pc_in` < BASE_ADDR or `pc_in` ≥ BASE_ADDR + 4·2**ADDR_W → `fault`=1, `fault_code`=10, stay IDLE. Comparison in 33-bit arithmetic, no wrap.
  - else → `mem_addr` loaded, `mem_req`=1, counter=0, `fault_code`=00, go WAIT.
- WAIT, each edge:
  - `mem_ack`=1 → `instr_out`←`mem_rdata`, `instr_valid`=1, `mem_req`=0, go IDLE.
  - else if counter = TIMEOUT-1 → `fault`=1, `fault_code`=11, `mem_req`=0, go IDLE.
  - else counter+1.
- `instr_valid`, `fault` are registered pulses; cleared at the next edge unless re-asserted.
- `fetch_busy` = (state = WAIT).
- `fetch_req` in WAIT ignored (not queued). `mem_ack` in IDLE ignored.
- `fault_code` cleared to 00 only on a successful acceptance; a timeout or rejection overwrites it.

## Timing
- Request accepted at edge N → `mem_req`/`fetch_busy` high from after edge N.
- `mem_ack` sampled high at edge N+k (k≥1) → `instr_valid` high for cycle after N+k; `mem_req` low same cycle. Minimum request-to-valid: 2 edges.
- Rejection at edge N → `fault` high for cycle after N; no `mem_req` ever.
- No ack → `mem_req` high exactly TIMEOUT cycles; `fault` in cycle following.
- `mem_ack` on the timeout edge: ack wins, no fault.
- Back-to-back: new request accepted in the cycle `instr_valid` or `fault` is high (state is IDLE).
- Reset mid-WAIT: next cycle `mem_req`=0, IDLE, all outputs at reset values; a later ack is ignored.

## Test plan
- Reset for 2 cycles with `fetch_req`=1, `mem_ack`=1 → all outputs at reset values, `mem_req` stays 0.
- `pc_in`=0x00003000, req 1 cycle; `mem_ack`=1 with `mem_rdata`=0x8C010000 on next edge → `mem_addr`=0, `instr_valid` one cycle, `instr_out`=0x8C010000, `fetch_busy` exactly 1 cycle.
- `pc_in`=0x00003FFC, ack after 3 cycles → `mem_addr`=0x3FF, `fetch_busy` 3 cycles; then `pc_in`=0x00004000 → `fault`, code 10; `pc_in`=0x00002FFC → code 10; no `mem_req`.
- `pc_in`=0x00003002 → `fault`, code 01, no `mem_req`; following valid request clears code to 00.
- Valid request, no ack → `mem_req` high 16 cycles, `fault` code 11; repeat with ack on 16th cycle → `instr_valid`, no fault.
- Valid request, `fetch_req` held high in WAIT with changed `pc_in` → `mem_addr` unchanged; reset asserted mid-WAIT then ack → no `instr_valid`, IDLE.
